// File: rtl/median_filter_pkg.sv
// rtl/median_filter_pkg.sv - mode encoding, FSM states and 3-input order helpers
package median_filter_pkg;

    typedef enum logic [1:0] {
        MODE_MED  = 2'b00,
        MODE_MIN  = 2'b01,
        MODE_MAX  = 2'b10,
        MODE_MED2 = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SORT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Helpers work on a wide word; callers zero-extend pixels and truncate back.
    localparam int MF_DW = 32;
    typedef logic [MF_DW-1:0] mf_word_t;

    function automatic mf_word_t min3(mf_word_t a, mf_word_t b, mf_word_t c);
        mf_word_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic mf_word_t max3(mf_word_t a, mf_word_t b, mf_word_t c);
        mf_word_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic mf_word_t med3(mf_word_t a, mf_word_t b, mf_word_t c);
        mf_word_t lo;
        mf_word_t hi;
        mf_word_t m;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        m  = (hi < c) ? hi : c;
        return (lo > m) ? lo : m;
    endfunction

endpackage

// File: rtl/mfe_sort9.sv
// rtl/mfe_sort9.sv - 3-stage registered 9-tap median/min/max selector
import median_filter_pkg::*;

module mfe_sort9 #(
    parameter int PIX_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  mode_e                 mode_i,
    input  logic [8:0][PIX_W-1:0] taps_i,
    output logic [PIX_W-1:0]      result_o
);

    logic [2:0][PIX_W-1:0] lo_q, md_q, hi_q;
    logic [PIX_W-1:0]      dlo_q, dmd_q, dhi_q, min_q, max_q, res_q;

    // Taps are row-major, so column c is taps c, 3+c, 6+c.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_q  <= '0;
            md_q  <= '0;
            hi_q  <= '0;
            dlo_q <= '0;
            dmd_q <= '0;
            dhi_q <= '0;
            min_q <= '0;
            max_q <= '0;
            res_q <= '0;
        end else if (en_i) begin
            for (int c = 0; c < 3; c++) begin
                lo_q[c] <= PIX_W'(min3(mf_word_t'(taps_i[c]), mf_word_t'(taps_i[3+c]), mf_word_t'(taps_i[6+c])));
                md_q[c] <= PIX_W'(med3(mf_word_t'(taps_i[c]), mf_word_t'(taps_i[3+c]), mf_word_t'(taps_i[6+c])));
                hi_q[c] <= PIX_W'(max3(mf_word_t'(taps_i[c]), mf_word_t'(taps_i[3+c]), mf_word_t'(taps_i[6+c])));
            end
            dlo_q <= PIX_W'(max3(mf_word_t'(lo_q[0]), mf_word_t'(lo_q[1]), mf_word_t'(lo_q[2])));
            dmd_q <= PIX_W'(med3(mf_word_t'(md_q[0]), mf_word_t'(md_q[1]), mf_word_t'(md_q[2])));
            dhi_q <= PIX_W'(min3(mf_word_t'(hi_q[0]), mf_word_t'(hi_q[1]), mf_word_t'(hi_q[2])));
            min_q <= PIX_W'(min3(mf_word_t'(lo_q[0]), mf_word_t'(lo_q[1]), mf_word_t'(lo_q[2])));
            max_q <= PIX_W'(max3(mf_word_t'(hi_q[0]), mf_word_t'(hi_q[1]), mf_word_t'(hi_q[2])));
            case (mode_i)
                MODE_MIN: res_q <= min_q;
                MODE_MAX: res_q <= max_q;
                default:  res_q <= PIX_W'(med3(mf_word_t'(dlo_q), mf_word_t'(dmd_q), mf_word_t'(dhi_q)));
            endcase
        end
    end

    assign result_o = res_q;

endmodule

// File: rtl/median_filter_engine_p.sv
// rtl/median_filter_engine_p.sv - 3x3 median/min/max image filter engine
// Optional macro MEDIAN_FILTER_REPLICATE_BORDER_EN: clamp border taps instead of zero-filling.
import median_filter_pkg::*;

module median_filter_engine_p #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int PIX_W = 8,
    parameter int AW    = $clog2(IMG_W*IMG_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic [AW-1:0]    iaddr,
    input  logic [PIX_W-1:0] idata,
    input  logic [PIX_W-1:0] data_rd,
    output logic [PIX_W-1:0] data_wr,
    output logic [AW-1:0]    addr,
    output logic             wen
);

    localparam int RB = $clog2(IMG_H);
    localparam int CB = $clog2(IMG_W);
    localparam int RW = RB + 2;
    localparam int CW = CB + 2;
    localparam logic [RB-1:0]        ROW_LAST = RB'(IMG_H - 1);
    localparam logic [CB-1:0]        COL_LAST = CB'(IMG_W - 1);
    localparam logic signed [RW-1:0] ROW_LIM  = RW'(IMG_H);
    localparam logic signed [CW-1:0] COL_LIM  = CW'(IMG_W);
    localparam logic signed [RW-1:0] ROW_M1   = '1;
    localparam logic signed [CW-1:0] COL_M1   = '1;

    state_e                state_q;
    mode_e                 mode_q;
    logic                  busy_q, wen_q;
    logic [AW-1:0]         addr_q;
    logic [RB-1:0]         row_q;
    logic [CB-1:0]         col_q;
    logic [3:0]            fcnt_q;
    logic [1:0]            scnt_q;
    logic [8:0][PIX_W-1:0] win_q;

    logic [1:0]            tap_r, tap_c;
    logic [3:0]            row_base;
    logic signed [RW-1:0]  tr;
    logic signed [CW-1:0]  tc;
    logic [RB-1:0]         cr;
    logic [CB-1:0]         cc;
    logic [PIX_W-1:0]      tap_d;
    logic [AW-1:0]         pix_addr;
    logic                  last_pix, fetch_last;
    logic                  unused_rd;

    assign unused_rd = ^data_rd;

    // Column 0 walks the whole window row-major; later columns fetch only the new right column.
    always_comb begin
        tap_r    = 2'd0;
        tap_c    = 2'd2;
        row_base = 4'd0;
        if (col_q == '0) begin
            tap_r    = (fcnt_q < 4'd3) ? 2'd0 : (fcnt_q < 4'd6) ? 2'd1 : 2'd2;
            row_base = (tap_r == 2'd0) ? 4'd0 : (tap_r == 2'd1) ? 4'd3 : 4'd6;
            tap_c    = 2'(fcnt_q - row_base);
        end else begin
            tap_r    = fcnt_q[1:0];
        end
    end

    assign tr = $signed({2'b00, row_q}) + $signed({{RB{1'b0}}, tap_r}) + ROW_M1;
    assign tc = $signed({2'b00, col_q}) + $signed({{CB{1'b0}}, tap_c}) + COL_M1;
    assign cr = tr[RW-1] ? '0 : (tr < ROW_LIM) ? tr[RB-1:0] : ROW_LAST;
    assign cc = tc[CW-1] ? '0 : (tc < COL_LIM) ? tc[CB-1:0] : COL_LAST;

    assign iaddr    = AW'(32'(cr) * IMG_W + 32'(cc));
    assign pix_addr = AW'(32'(row_q) * IMG_W + 32'(col_q));

`ifdef MEDIAN_FILTER_REPLICATE_BORDER_EN
    assign tap_d = idata;
`else
    logic tap_ok;
    assign tap_ok = !tr[RW-1] && (tr < ROW_LIM) && !tc[CW-1] && (tc < COL_LIM);
    assign tap_d  = tap_ok ? idata : '0;
`endif

    assign last_pix   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign fetch_last = (col_q == '0) ? (fcnt_q == 4'd8) : (fcnt_q == 4'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_MED;
            busy_q  <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            fcnt_q  <= '0;
            scnt_q  <= '0;
            win_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ready) begin
                        state_q <= ST_FETCH;
                        mode_q  <= mode_e'(mode);
                        busy_q  <= 1'b1;
                        row_q   <= '0;
                        col_q   <= '0;
                        fcnt_q  <= '0;
                    end
                end
                ST_FETCH: begin
                    if (col_q == '0) begin
                        win_q[fcnt_q] <= tap_d;
                    end else if (fcnt_q == 4'd0) begin
                        for (int r = 0; r < 3; r++) begin
                            win_q[3*r]   <= win_q[3*r+1];
                            win_q[3*r+1] <= win_q[3*r+2];
                        end
                        win_q[2] <= tap_d;
                    end else if (fcnt_q == 4'd1) begin
                        win_q[5] <= tap_d;
                    end else begin
                        win_q[8] <= tap_d;
                    end
                    if (fetch_last) begin
                        state_q <= ST_SORT;
                        scnt_q  <= '0;
                    end else begin
                        fcnt_q  <= fcnt_q + 4'd1;
                    end
                end
                ST_SORT: begin
                    if (scnt_q == 2'd2) begin
                        state_q <= ST_WRITE;
                        wen_q   <= 1'b1;
                        addr_q  <= pix_addr;
                    end else begin
                        scnt_q  <= scnt_q + 2'd1;
                    end
                end
                ST_WRITE: begin
                    wen_q  <= 1'b0;
                    fcnt_q <= '0;
                    if (last_pix) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_FETCH;
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    row_q   <= '0;
                    col_q   <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mfe_sort9 #(.PIX_W(PIX_W)) u_sort9 (
        .clk      (clk),
        .reset    (reset),
        .en_i     (state_q == ST_SORT),
        .mode_i   (mode_q),
        .taps_i   (win_q),
        .result_o (data_wr)
    );

    assign busy = busy_q;
    assign wen  = wen_q;
    assign addr = addr_q;

endmodule

// File: tb/tb_median_filter_engine_p.sv
// tb/tb_median_filter_engine_p.sv - self-checking bench for a 4x4 median_filter_engine_p
module tb_median_filter_engine_p;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int AW = 4;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic [1:0]    mode;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [PW-1:0] idata;
    logic [PW-1:0] data_rd;
    logic [PW-1:0] data_wr;
    logic [AW-1:0] addr;
    logic          wen;

    logic [PW-1:0] img [N];
    logic [PW-1:0] got [N];
    logic [1:0]    cur_mode;
    int            n_vec = 0;
    int            n_err = 0;
    int            exp_idx = 0;
    int            wen_cnt = 0;
    int            busy_cnt = 0;

    median_filter_engine_p #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .ready   (ready),
        .mode    (mode),
        .busy    (busy),
        .iaddr   (iaddr),
        .idata   (idata),
        .data_rd (data_rd),
        .data_wr (data_wr),
        .addr    (addr),
        .wen     (wen)
    );

    assign idata = img[iaddr];

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Reference filter straight from the definition: gather 9 neighbours, sort, pick.
    function automatic int model_pix(input int idx, input logic [1:0] m);
        int v[9];
        int r, c, rr, cc, k, t;
        r = idx / W;
        c = idx % W;
        k = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
`ifdef MEDIAN_FILTER_REPLICATE_BORDER_EN
                rr = (rr < 0) ? 0 : (rr >= H) ? H - 1 : rr;
                cc = (cc < 0) ? 0 : (cc >= W) ? W - 1 : cc;
                v[k] = int'(img[rr*W + cc]);
`else
                if (rr < 0 || rr >= H || cc < 0 || cc >= W) v[k] = 0;
                else v[k] = int'(img[rr*W + cc]);
`endif
                k++;
            end
        end
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
        end
        case (m)
            2'b01:   return v[0];
            2'b10:   return v[8];
            default: return v[4];
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (wen) begin
                check("wen_outside_busy", int'(busy), 1);
                check("wr_addr", int'(addr), exp_idx);
                check("wr_data", int'(data_wr), model_pix(int'(addr), cur_mode));
                got[addr] = data_wr;
                exp_idx++;
                wen_cnt++;
            end
        end
    end

    task automatic start_image(input logic [1:0] m);
        @(posedge clk); #1;
        exp_idx  = 0;
        wen_cnt  = 0;
        busy_cnt = 0;
        cur_mode = m;
        mode     = m;
        ready    = 1'b1;
        @(posedge clk); #1;
        ready    = 1'b0;
        mode     = ~m;
    endtask

    task automatic finish_image();
        int t;
        t = 0;
        while (!busy && t < 10) begin @(posedge clk); #1; t++; end
        check("busy_rise", int'(busy), 1);
        t = 0;
        while (busy && t < 2000) begin @(posedge clk); #1; t++; end
        check("busy_fall", int'(busy), 0);
        @(posedge clk); #1;
        check("wen_count", wen_cnt, N);
        check("busy_cycles", busy_cnt, H * (13 + 7 * (W - 1)));
    endtask

    initial begin
        int t;
        reset   = 1'b1;
        ready   = 1'b0;
        mode    = 2'b00;
        data_rd = '0;
        for (int i = 0; i < N; i++) img[i] = '0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_wen", int'(wen), 0);
        check("rst_data_wr", int'(data_wr), 0);
        check("rst_addr", int'(addr), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Flat image, median.
        for (int i = 0; i < N; i++) img[i] = 8'd100;
        start_image(2'b00);
        finish_image();
`ifdef MEDIAN_FILTER_REPLICATE_BORDER_EN
        check("flat_corner", int'(got[0]), 100);
`else
        check("flat_corner", int'(got[0]), 0);
`endif
        check("flat_edge", int'(got[1]), 100);
        check("flat_inner", int'(got[5]), 100);

        // Ramp image, max.
        for (int i = 0; i < N; i++) img[i] = PW'(i);
        start_image(2'b10);
        finish_image();
        check("ramp_max_11", int'(got[5]), 10);
        check("ramp_max_00", int'(got[0]), 5);
        check("ramp_max_33", int'(got[15]), 15);

        // Ramp image, min, with ready and mode toggled mid-image.
        start_image(2'b01);
        repeat (5) @(posedge clk);
        #1;
        ready = 1'b1;
        mode  = 2'b10;
        repeat (20) @(posedge clk);
        #1;
        ready = 1'b0;
        finish_image();
        check("ramp_min_22", int'(got[10]), 5);

        // Random image, median via the 11 encoding.
        for (int i = 0; i < N; i++) img[i] = PW'($urandom_range(0, 255));
        start_image(2'b11);
        finish_image();

        // Abort during the fetch of pixel 5, then restart.
        for (int i = 0; i < N; i++) img[i] = PW'($urandom_range(0, 255));
        start_image(2'b00);
        t = 0;
        while (wen_cnt < 5 && t < 500) begin @(posedge clk); #1; t++; end
        check("reach_pixel5", wen_cnt, 5);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_wen", int'(wen), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start_image(2'b00);
        finish_image();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/median_filter_engine_p.md
MEDIAN_FILTER_ENGINE_P -- requirements
Module: median_filter_engine_p

Interface
REQ-001 Parameter IMG_W, default 128, image width in pixels (>=3).
REQ-002 Parameter IMG_H, default 128, image height in pixels (>=3).
REQ-003 Parameter PIX_W, default 8, pixel width in bits.
REQ-004 Parameter AW, default $clog2(IMG_W*IMG_H), address width.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ready  input  1  start request, sampled in IDLE only.
REQ-008 mode  input  2  00/11 median, 01 min, 10 max; latched with ready.
REQ-009 busy  output  1  high while an image is in progress.
REQ-010 iaddr  output  AW  source image address, row*IMG_W+col.
REQ-011 idata  input  PIX_W  source pixel; combinational response to iaddr in the same cycle.
REQ-012 data_rd  input  PIX_W  result-memory read data; unused, kept for port compatibility.
REQ-013 data_wr  output  PIX_W  result pixel.
REQ-014 addr  output  AW  result address, row*IMG_W+col.
REQ-015 wen  output  1  result write strobe, one cycle per pixel.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, SORT, WRITE, DONE; IDLE->FETCH on ready; FETCH->SORT when the fetch count is reached; SORT->WRITE after 3 cycles; WRITE->FETCH, or WRITE->DONE on the last pixel; DONE->IDLE after 1 cycle.
REQ-017 Raster order SHALL be row 0..IMG_H-1, col 0..IMG_W-1 within each row.
REQ-018 At col 0, FETCH SHALL last 9 cycles and load the full 3x3 window, row-major.
REQ-019 At col>0, FETCH SHALL last 3 cycles: shift the window left one column, then fetch the new right column top to bottom.
REQ-020 Neighbour coordinates SHALL be compared as signed values; col-1 at col 0 and col+1 at IMG_W-1 are out of range, with no wrap to the adjacent row; the same applies to rows.
REQ-021 Out-of-range taps SHALL be substituted with 0; iaddr value on those cycles is don't-care.
REQ-022 SORT SHALL select per mode: median, min or max of the 9 taps; latency is 3 cycles in every mode.
REQ-023 In WRITE, wen=1 for exactly one cycle with data_wr=result and addr=current pixel address; wen=0 in all other states.
REQ-024 busy SHALL be 1 in FETCH/SORT/WRITE and 0 in IDLE/DONE.
REQ-025 ready while busy SHALL be ignored; mode changes mid-image SHALL be ignored.
REQ-026 Cycles per image SHALL equal IMG_H*(13 + 7*(IMG_W-1)).

Reset
REQ-027 Reset SHALL force IDLE, busy=0, wen=0, data_wr=0, addr=0, row/col counters=0, and all window taps=0.
REQ-028 Reset mid-image SHALL abort with no partial resume; the next ready restarts at pixel 0.

Configuration
REQ-029 Macro MEDIAN_FILTER_REPLICATE_BORDER_EN defined: out-of-range taps take the nearest in-range pixel (coordinates clamped to the image); without it, zero substitution per REQ-021 applies.

Structure
REQ-030 Package median_filter_pkg SHALL hold the mode encoding, the FSM state typedef, and the min3/med3/max3 functions.
REQ-031 Sub-module mfe_sort9 SHALL implement the 3-stage registered 9-tap selector (column sort, diagonal select, final select).

Verification (IMG_W=IMG_H=4 unless stated)
REQ-032 All pixels 100, median, no macro -> corners 0, non-corner edges 100, interior 100.
REQ-033 All pixels 100, median, macro defined -> all 16 outputs 100.
REQ-034 Pixel = address (0..15), max mode, no macro -> out(1,1)=10, out(0,0)=5, out(3,3)=15.
REQ-035 Any image -> exactly 16 wen pulses, addr 0..15 ascending, busy high exactly 136 cycles.
REQ-036 Reset asserted during FETCH of pixel 5 -> busy=0 and wen=0 immediately; the next ready produces its first write at addr 0 with a correct value.
REQ-037 Default 128x128, pixel = address mod 256, median -> out(64,64) matches a software reference and row 0 never reads row 1's wrap-around pixels.
